// File: rtl/reload_down_counter_if.sv
// Bus bundle for reload_down_counter: CPU-side write strobes, count controls
// and the registered count/terminal-count outputs.
interface reload_down_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             reload_wr;
  logic [WIDTH-1:0] reload_d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  modport master (
    output en, tick, load, d, reload_wr, reload_d,
    input  q, tc, busy
  );

  modport slave (
    input  en, tick, load, d, reload_wr, reload_d,
    output q, tc, busy
  );
endinterface

// File: rtl/reload_down_counter.sv
// Loadable down-counter with automatic reload and a one-cycle terminal-count
// pulse, used for period and length timers.
//
//   state  | meaning
//   COUNT  | decrement on qualified tick, accept loads
//   RELOAD | wrap value shown for one cycle; next edge applies the reload
module reload_down_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INITIAL_Q = '0
) (
  input logic                   clk,
  input logic                   nreset,
  reload_down_counter_if.slave  bus
);

  typedef enum logic [0:0] {
    COUNT  = 1'b0,
    RELOAD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_eff;
  logic             tc_q, tc_d;

  // A reload write in the RELOAD cycle is used immediately (write-through).
  assign reload_eff = bus.reload_wr ? bus.reload_d : reload_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    unique case (state_q)
      COUNT: begin
        if (bus.load) begin
          q_d = bus.d;
        end else if (bus.en && bus.tick) begin
          if (q_q != '0) begin
            q_d = q_q - 1'b1;
          end else begin
            q_d     = '1;
            state_d = RELOAD;
          end
        end
      end
      RELOAD: begin
        state_d = COUNT;
        if (bus.load) begin
          q_d = bus.d;
        end else begin
          q_d  = reload_eff;
          tc_d = 1'b1;
        end
      end
      default: state_d = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= COUNT;
      q_q      <= INITIAL_Q;
      reload_q <= INITIAL_Q;
      tc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      if (bus.reload_wr) begin
        reload_q <= bus.reload_d;
      end
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == RELOAD);

endmodule

// File: tb/tb_reload_down_counter.sv
// Randomized and directed bench for reload_down_counter: a behavioural model
// predicts each cycle's outputs into a scoreboard that a monitor drains.
module tb_reload_down_counter;

  localparam int         WIDTH     = 8;
  localparam logic [7:0] INITIAL_Q = 8'h05;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       busy;
  } exp_t;

  logic clk;
  logic nreset;

  reload_down_counter_if #(.WIDTH(WIDTH)) bus ();

  reload_down_counter #(.WIDTH(WIDTH), .INITIAL_Q(INITIAL_Q)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  exp_t sb[$];

  // Reference model: count value, stored reload, and "wrapped, reload due".
  logic [7:0] m_q;
  logic [7:0] m_rel;
  logic       m_due;
  logic       m_tc;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("q",    bus.q,           e.q);
      check("tc",   {7'd0, bus.tc},   {7'd0, e.tc});
      check("busy", {7'd0, bus.busy}, {7'd0, e.busy});
    end
  end

  task automatic step(input logic rst_n, input logic en, input logic tick,
                      input logic load, input logic [7:0] d,
                      input logic rwr, input logic [7:0] rd);
    logic [7:0] eff;
    exp_t e;
    @(negedge clk);
    nreset        = rst_n;
    bus.en        = en;
    bus.tick      = tick;
    bus.load      = load;
    bus.d         = d;
    bus.reload_wr = rwr;
    bus.reload_d  = rd;
    if (!rst_n) begin
      m_q   = INITIAL_Q;
      m_rel = INITIAL_Q;
      m_due = 1'b0;
      m_tc  = 1'b0;
    end else begin
      eff  = rwr ? rd : m_rel;
      m_tc = 1'b0;
      if (m_due) begin
        m_due = 1'b0;
        if (load) m_q = d;
        else begin
          m_q  = eff;
          m_tc = 1'b1;
        end
      end else if (load) begin
        m_q = d;
      end else if (en && tick) begin
        if (m_q == 8'd0) begin
          m_q   = 8'hFF;
          m_due = 1'b1;
        end else begin
          m_q = m_q - 8'd1;
        end
      end
      if (rwr) m_rel = rd;
    end
    e.q    = m_q;
    e.tc   = m_tc;
    e.busy = m_due;
    sb.push_back(e);
  endtask

  // Direct check of a literal value right after the edge the last step targeted.
  task automatic lit(input string name, input logic [7:0] q, input logic tc);
    @(posedge clk);
    #2;
    check({name, "_q"},  bus.q, q);
    check({name, "_tc"}, {7'd0, bus.tc}, {7'd0, tc});
  endtask

  task automatic idle(input logic en, input logic tick);
    step(1'b1, en, tick, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_load(input logic [7:0] v);
    step(1'b1, 1'b0, 1'b0, 1'b1, v, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] seq_q [10];
    logic       seq_tc[10];
    nreset = 1'b0;
    bus.en = 1'b0; bus.tick = 1'b0; bus.load = 1'b0;
    bus.d = '0; bus.reload_wr = 1'b0; bus.reload_d = '0;
    m_q = INITIAL_Q; m_rel = INITIAL_Q; m_due = 1'b0; m_tc = 1'b0;

    // Reset values
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(1'b0, 1'b0);
    lit("reset", 8'h05, 1'b0);
    idle(1'b1, 1'b1);
    lit("first_tick", 8'h04, 1'b0);

    // Countdown and reload, reload=03
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03);
    do_load(8'h02);
    lit("cd_load", 8'h02, 1'b0);
    seq_q  = '{8'h01, 8'h00, 8'hFF, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h03, 8'h02};
    seq_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      idle(1'b1, 1'b1);
      lit("countdown", seq_q[i], seq_tc[i]);
    end

    // Load during RELOAD cancels tc
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
    do_load(8'h00);
    idle(1'b1, 1'b1);
    lit("wrap", 8'hFF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h7A, 1'b0, 8'h00);
    lit("load_in_reload", 8'h7A, 1'b0);
    idle(1'b1, 1'b1);
    lit("resume", 8'h79, 1'b0);

    // Write-through in RELOAD cycle
    do_load(8'h00);
    idle(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22);
    lit("write_through", 8'h22, 1'b1);
    do_load(8'h00);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    lit("stored_22", 8'h22, 1'b1);

    // Gating and priority
    for (int i = 0; i < 10; i++) idle(1'b0, 1'b1);
    lit("gated", 8'h22, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
    lit("load_beats_tick", 8'h40, 1'b0);
    do_load(8'h00);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    lit("en_drop_reload", 8'h22, 1'b1);

    // Reset mid-reload
    do_load(8'h00);
    idle(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    lit("reset_in_reload", 8'h05, 1'b0);
    do_load(8'h00);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    lit("reload_reset_val", 8'h05, 1'b1);

    // Randomized traffic with small values so underflows are frequent
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
           ($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 4)));
    end

    idle(1'b0, 1'b0);
    begin
      int budget = 10;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #3;
      if (sb.size() > 0) begin
        n_total++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reload_down_counter.md
# reload_down_counter

Synchronous, loadable down-counter with automatic reload and terminal-count pulse. It is the decrementing counterpart of the toggle-cell ripple up-counters used for the timer and divider chains. It serves APU-style period and length timers: the CPU bus writes the count or reload value, and the block counts down on `tick` and fires `tc` on each reload. All state is clocked on the rising edge of `clk`. There are no asynchronous paths, unlike the gate-level cells.

## Interface
- `WIDTH`, default 8: counter and reload register width.
- `INITIAL_Q`, default 0: count value after reset; also the reset value of the reload register.
- `clk` in 1: single clock; all registers update on its rising edge.
- `nreset` in 1: synchronous, active-low reset.
- `en` in 1: count enable; when low, `tick` is ignored.
- `tick` in 1: decrement strobe, one cycle wide, qualified by `en`.
- `load` in 1: write strobe for the count.
- `d` in WIDTH: count value written on `load`.
- `reload_wr` in 1: write strobe for the reload register.
- `reload_d` in WIDTH: reload value written on `reload_wr`.
- `q` out WIDTH: current count, registered.
- `tc` out 1: terminal-count pulse, one cycle high when the reload is applied.
- `busy` out 1: high while the FSM is in RELOAD.

## Operation
- **Reset** (`nreset`=0 at a clock edge):
  - `q`=INITIAL_Q, reload register=INITIAL_Q.
  - State=COUNT, `tc`=0, `busy`=0.
  - Reset overrides every other input in that cycle.
- **FSM states:** COUNT and RELOAD.
- **COUNT transitions:**
  - `load`=1: `q`<=`d`. Any tick that cycle is discarded. Stay in COUNT.
  - Else `en`&`tick` and `q`!=0: `q`<=`q`-1, modulo 2^WIDTH is never reached here.
  - Else `en`&`tick` and `q`==0: `q`<=all ones (wrap value visible for exactly one cycle). Go to RELOAD.
  - Otherwise hold.
- **RELOAD transitions** (always lasts exactly one cycle; `en` and `tick` are ignored):
  - `load`=1: `q`<=`d`, `tc` stays 0, reload is cancelled. Go to COUNT.
  - Else: `q`<=effective reload value, `tc`<=1 for the next cycle. Go to COUNT.
- **Effective reload value:**
  - If `reload_wr`=1 in the same cycle, it is `reload_d` (write-through).
  - Otherwise it is the stored reload register.
- **Reload register:**
  - Written on any cycle with `reload_wr`=1, in any state.
  - Never modified by counting.
- **`en` behaviour:** dropping `en` does not abort a pending RELOAD.
- **`tick` width:** a `tick` held high for N cycles is N decrements; there is no edge detection.
- **Arithmetic:** all of it is unsigned WIDTH-bit. A reload value of 0 is legal: the next qualified tick underflows again immediately.
- **Outputs:** `q`, `tc` and `busy` are registered outputs with no combinational path from any input.

## Timing
- **Latency:** 1 clock from a qualified `tick` or `load` to the updated `q`.
- **Underflow to reload sequence:**
  - Edge k: the tick is sampled with `q`=0.
  - Edge k+1: `q`=all ones, `busy`=1.
  - Edge k+2: `q`=reload value, `tc`=1, `busy`=0.
  - Edge k+3: `tc`=0.
- **Minimum reload period:** with reload value R and tick every cycle, `tc` fires every R+2 cycles (R decrements, the wrap cycle, the reload cycle).
- **Simultaneous events:**
  - `load` beats `tick` in every state.
  - `load` during RELOAD suppresses `tc`.
  - `reload_wr` during RELOAD is used by that reload.
  - `nreset` beats everything.
- **Reset mid-operation:**
  - Reset in RELOAD returns to COUNT with `q`=INITIAL_Q.
  - No `tc` is emitted.

## Test plan
- **Reset values:** WIDTH=8, INITIAL_Q=8'h05. Hold `nreset`=0 for 2 cycles, then release -> `q`=05, `tc`=0, `busy`=0. One tick with `reload_wr`=0 -> `q`=04.
- **Countdown and reload:**
  - Setup: `reload_wr` with `reload_d`=03, `load` `d`=02, then `en`=1 and `tick` every cycle.
  - `q` must read 02,01,00,FF,03,02,01,00,FF,03.
  - `tc`=1 exactly on the cycles where `q`=03 after FF; period is 5 cycles.
- **Load during RELOAD:** underflow with reload=10 and `load` `d`=7A on the wrap cycle -> `q`=7A, `tc` never asserts, counting resumes from 7A on the next tick.
- **Write-through:** underflow with stored reload=10 and `reload_wr` `reload_d`=22 in the RELOAD cycle -> `q`=22, `tc`=1, reload register reads back 22 on the next underflow.
- **Gating and priority:**
  - `en`=0 with ticks for 10 cycles -> `q` unchanged.
  - `load` `d`=40 together with a qualified tick -> `q`=40, not 3F.
  - `en` dropped in the wrap cycle -> reload still completes and `tc` pulses.
- **Reset mid-reload:** assert `nreset`=0 in the RELOAD cycle -> next `q`=INITIAL_Q, `tc`=0, `busy`=0. Reload register returns to INITIAL_Q.
